// File: rtl/median_denoise_if.sv
// -----------------------------------------------------------------------------
// median_denoise_if
// Beat bus carrying one colour-channel sample per cycle, as produced by the
// demosaic stage and as emitted by median_denoise.
//   valid    : beat strobe
//   data     : channel sample, DATA_W bits
//   color    : 0=R, 1=G, 2=B, 3=invalid
//   col_last : last pixel of the column strip (meaningful on B beats)
//   pic_last : last pixel of the picture (meaningful on B beats)
// Modports: master drives the beat, slave receives it. No backpressure.
// -----------------------------------------------------------------------------
interface median_denoise_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [1:0]        color;
  logic              col_last;
  logic              pic_last;

  modport master (output valid, data, color, col_last, pic_last);
  modport slave  (input  valid, data, color, col_last, pic_last);
endinterface

// File: rtl/median_denoise.sv
// -----------------------------------------------------------------------------
// median_denoise
// Per-channel 3-tap median filter along each column strip of the demosaic
// RGB beat stream. Removes single-pixel impulse noise. The output for pixel n
// is emitted while pixel n+1 arrives; the last pixel of a column is replayed
// by a three-beat flush (R, G, B) after the column's final B beat.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   in_bus  : slave side of the input beat bus
//   out_bus : master side of the output beat bus (all fields registered)
// -----------------------------------------------------------------------------
module median_denoise #(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  median_denoise_if.slave  in_bus,
  median_denoise_if.master out_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FL_R = 2'd1,
    FL_G = 2'd2,
    FL_B = 2'd3
  } state_t;

  localparam logic [1:0] COL_R    = 2'd0;
  localparam logic [1:0] COL_G    = 2'd1;
  localparam logic [1:0] COL_B    = 2'd2;
  localparam logic [1:0] COL_NONE = 2'd3;

  // Median of three with three unsigned comparators; ties return the
  // repeated value because >= resolves equal pairs consistently.
  function automatic logic [DATA_W-1:0] med3(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic [DATA_W-1:0] z
  );
    logic              ge_xy;
    logic              ge_yz;
    logic              ge_xz;
    logic [DATA_W-1:0] m;
    ge_xy = (x >= y);
    ge_yz = (y >= z);
    ge_xz = (x >= z);
    if (ge_xy) begin
      if (ge_yz) begin
        m = y;
      end else if (ge_xz) begin
        m = z;
      end else begin
        m = x;
      end
    end else begin
      if (ge_xz) begin
        m = x;
      end else if (ge_yz) begin
        m = z;
      end else begin
        m = y;
      end
    end
    return m;
  endfunction

  // Per-channel history: a_r = p[n-1], b_r = p[n]; tail_r holds the flushed pixel.
  logic [DATA_W-1:0] a_r    [3];
  logic [DATA_W-1:0] b_r    [3];
  logic [DATA_W-1:0] tail_r [3];
  logic              tail_pic_r;
  logic              first_r;
  state_t            state_r;
  state_t            state_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [1:0]        out_color_r;
  logic              out_col_last_r;
  logic              out_pic_last_r;

  logic              beat_s;
  logic              col_end_s;
  logic              emit_s;
  logic              load_tail_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [DATA_W-1:0] med_s;

  logic              nxt_valid_s;
  logic [DATA_W-1:0] nxt_data_s;
  logic [1:0]        nxt_color_s;
  logic              nxt_col_last_s;
  logic              nxt_pic_last_s;

  // Input beat decode, history select for the incoming channel, and median.
  always_comb begin
    beat_s    = in_bus.valid && (in_bus.color != COL_NONE);
    col_end_s = beat_s && (in_bus.color == COL_B) && in_bus.col_last;
    emit_s    = beat_s && !first_r;
    sel_a_s   = '0;
    sel_b_s   = '0;
    case (in_bus.color)
      COL_R: begin
        sel_a_s = a_r[0];
        sel_b_s = b_r[0];
      end
      COL_G: begin
        sel_a_s = a_r[1];
        sel_b_s = b_r[1];
      end
      COL_B: begin
        sel_a_s = a_r[2];
        sel_b_s = b_r[2];
      end
      default: begin
        sel_a_s = '0;
        sel_b_s = '0;
      end
    endcase
    med_s = med3(sel_a_s, sel_b_s, in_bus.data);
  end

  // Flush sequencer next state. A col_last landing on FL_B (single pixel
  // right behind the previous column) restarts the flush cleanly because
  // FL_B reads the old tail in the same cycle the new tail is loaded.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (col_end_s) begin
          state_s = FL_R;
        end else begin
          state_s = IDLE;
        end
      end
      FL_R: state_s = FL_G;
      FL_G: state_s = FL_B;
      FL_B: begin
        if (col_end_s) begin
          state_s = FL_R;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
    load_tail_s = (state_s == FL_R);
  end

  // Next output beat: flush beats while flushing, otherwise the regular
  // median. A new column's beats during a flush are pixel-0 beats and never
  // emit, so the two sources cannot collide.
  always_comb begin
    nxt_valid_s    = 1'b0;
    nxt_data_s     = out_data_r;
    nxt_color_s    = out_color_r;
    nxt_col_last_s = 1'b0;
    nxt_pic_last_s = 1'b0;
    case (state_r)
      FL_R: begin
        nxt_valid_s = 1'b1;
        nxt_data_s  = tail_r[0];
        nxt_color_s = COL_R;
      end
      FL_G: begin
        nxt_valid_s = 1'b1;
        nxt_data_s  = tail_r[1];
        nxt_color_s = COL_G;
      end
      FL_B: begin
        nxt_valid_s    = 1'b1;
        nxt_data_s     = tail_r[2];
        nxt_color_s    = COL_B;
        nxt_col_last_s = 1'b1;
        nxt_pic_last_s = tail_pic_r;
      end
      IDLE: begin
        if (emit_s) begin
          nxt_valid_s = 1'b1;
          nxt_data_s  = med_s;
          nxt_color_s = in_bus.color;
        end else begin
          nxt_valid_s = 1'b0;
        end
      end
      default: nxt_valid_s = 1'b0;
    endcase
  end

  // State, history, tail and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      first_r        <= 1'b1;
      tail_pic_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      out_color_r    <= 2'd0;
      out_col_last_r <= 1'b0;
      out_pic_last_r <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        a_r[c]    <= '0;
        b_r[c]    <= '0;
        tail_r[c] <= '0;
      end
    end else begin
      state_r        <= state_s;
      out_valid_r    <= nxt_valid_s;
      out_data_r     <= nxt_data_s;
      out_color_r    <= nxt_color_s;
      out_col_last_r <= nxt_col_last_s;
      out_pic_last_r <= nxt_pic_last_s;
      for (int c = 0; c < 3; c++) begin
        if (beat_s && (in_bus.color == c[1:0])) begin
          // Pixel 0 seeds both taps so pixel 0 sees median(p0, p0, p1) = p0.
          a_r[c] <= first_r ? in_bus.data : b_r[c];
          b_r[c] <= in_bus.data;
        end
      end
      // The first-pixel flag stays set through pixel 0's R/G/B and is
      // re-armed by a col_last on the B beat.
      if (beat_s && (in_bus.color == COL_B)) begin
        first_r <= in_bus.col_last;
      end
      if (load_tail_s) begin
        tail_r[0]  <= b_r[0];
        tail_r[1]  <= b_r[1];
        tail_r[2]  <= in_bus.data;
        tail_pic_r <= in_bus.pic_last;
      end
    end
  end

  assign out_bus.valid    = out_valid_r;
  assign out_bus.data     = out_data_r;
  assign out_bus.color    = out_color_r;
  assign out_bus.col_last = out_col_last_r;
  assign out_bus.pic_last = out_pic_last_r;

endmodule

// File: tb/tb_median_denoise.sv
// -----------------------------------------------------------------------------
// tb_median_denoise
// Self-checking bench for median_denoise. Expected beats (value, channel,
// flags and the exact output cycle) are queued as stimulus is driven and
// checked against the DUT output at each falling edge.
// -----------------------------------------------------------------------------
module tb_median_denoise;
  localparam int DATA_W = 8;

  typedef logic [2:0][7:0] pix_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] color;
    logic       col_last;
    logic       pic_last;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] mid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  median_denoise_if #(.DATA_W(DATA_W)) in_bus ();
  median_denoise_if #(.DATA_W(DATA_W)) out_bus ();

  median_denoise #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  // Reference median: sort three values, take the middle one.
  function automatic logic [7:0] ref_med(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    logic [7:0] v0, v1, v2, t;
    v0 = x; v1 = y; v2 = z;
    if (v0 > v1) begin t = v0; v0 = v1; v1 = t; end
    if (v1 > v2) begin t = v1; v1 = v2; v2 = t; end
    if (v0 > v1) begin t = v0; v0 = v1; v1 = t; end
    return v1;
  endfunction

  // Windowed median with edge replication; the last pixel passes through.
  task automatic model_col(input pix_t px[8], input int h, output pix_t ex[8]);
    for (int i = 0; i < 8; i++) ex[i] = '0;
    for (int i = 0; i < h; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (i == h - 1) ex[i][c] = px[i][c];
        else ex[i][c] = ref_med(px[(i > 0) ? i - 1 : 0][c], px[i][c], px[i + 1][c]);
      end
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic [1:0] c,
                      input logic cl, input logic pl, output int en);
    in_bus.valid    = v;
    in_bus.data     = d;
    in_bus.color    = c;
    in_bus.col_last = cl;
    in_bus.pic_last = pl;
    @(posedge clk);
    #1;
    en = cyc;
    in_bus.valid    = 1'b0;
    in_bus.col_last = 1'b0;
    in_bus.pic_last = 1'b0;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) beat(1'b0, 8'd0, 2'd0, 1'b0, 1'b0, e);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] c, input logic cl,
                          input logic pl, input int at);
    exp_t x;
    x.data = d; x.color = c; x.col_last = cl; x.pic_last = pl; x.cyc = at;
    sb_q.push_back(x);
  endtask

  // Drives one column. junk_at inserts a color=3 beat (with flags set) before
  // that pixel's R beat; junk_cl raises col_last/pic_last on every R and G beat.
  task automatic send_col(input pix_t px[8], input pix_t ex[8], input int h,
                          input logic pic_last, input int junk_at, input bit junk_cl,
                          input bit push_flush, output int k);
    int   e;
    logic last_b;
    logic fake;
    e = 0;
    for (int i = 0; i < h; i++) begin
      if (i == junk_at) beat(1'b1, 8'hFF, 2'd3, 1'b1, 1'b1, e);
      for (int c = 0; c < 3; c++) begin
        last_b = (c == 2) && (i == h - 1);
        fake   = junk_cl && (c != 2);
        beat(1'b1, px[i][c], c[1:0], last_b | fake, (last_b & pic_last) | fake, e);
        if (i > 0) push_exp(ex[i - 1][c], c[1:0], 1'b0, 1'b0, e);
      end
    end
    k = e;
    if (push_flush) begin
      for (int c = 0; c < 3; c++)
        push_exp(ex[h - 1][c], c[1:0], c == 2, (c == 2) & pic_last, k + 1 + c);
    end
  endtask

  task automatic rand_col(input int h, output pix_t px[8]);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 3; c++)
        px[i][c] = (i < h) ? 8'($urandom_range(0, 255)) : 8'd0;
  endtask

  initial begin
    pix_t px[8];
    pix_t ex[8];
    vec_t tbl[8];
    int   k;
    logic [7:0] r_exp[8];

    tbl[0] = '{8'd1,   8'd2,   8'd3,   8'd2};
    tbl[1] = '{8'd3,   8'd2,   8'd1,   8'd2};
    tbl[2] = '{8'd255, 8'd0,   8'd128, 8'd128};
    tbl[3] = '{8'd7,   8'd7,   8'd3,   8'd7};
    tbl[4] = '{8'd0,   8'd255, 8'd255, 8'd255};
    tbl[5] = '{8'd9,   8'd1,   8'd9,   8'd9};
    tbl[6] = '{8'd200, 8'd200, 8'd200, 8'd200};
    tbl[7] = '{8'd0,   8'd255, 8'd0,   8'd0};

    in_bus.valid = 1'b0; in_bus.data = 8'd0; in_bus.color = 2'd0;
    in_bus.col_last = 1'b0; in_bus.pic_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_bus.valid !== 1'b0 || out_bus.data !== 8'd0 || out_bus.color !== 2'd0 ||
        out_bus.col_last !== 1'b0 || out_bus.pic_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%0d c=%0d cl=%b pl=%b, want all 0",
               out_bus.valid, out_bus.data, out_bus.color, out_bus.col_last, out_bus.pic_last);
    end
    rst = 1'b0;

    fork
      begin : monitor
        exp_t x;
        forever begin
          @(negedge clk);
          while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL missing_beat: got nothing at cycle %0d, want d=%0d c=%0d",
                     sb_q[0].cyc, sb_q[0].data, sb_q[0].color);
            void'(sb_q.pop_front());
          end
          if (out_bus.valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_beat: got d=%0d c=%0d at cycle %0d, want no beat",
                       out_bus.data, out_bus.color, cyc);
            end else begin
              x = sb_q.pop_front();
              if (out_bus.data !== x.data || out_bus.color !== x.color ||
                  out_bus.col_last !== x.col_last || out_bus.pic_last !== x.pic_last ||
                  cyc != x.cyc) begin
                bad++;
                $display("FAIL out_beat: got d=%0d c=%0d cl=%b pl=%b @%0d, want d=%0d c=%0d cl=%b pl=%b @%0d",
                         out_bus.data, out_bus.color, out_bus.col_last, out_bus.pic_last, cyc,
                         x.data, x.color, x.col_last, x.pic_last, x.cyc);
              end
            end
          end else if (out_bus.col_last !== 1'b0 || out_bus.pic_last !== 1'b0) begin
            total++; bad++;
            $display("FAIL flag_no_valid: got cl=%b pl=%b at cycle %0d, want 0 0",
                     out_bus.col_last, out_bus.pic_last, cyc);
          end
        end
      end
    join_none

    idle(2);

    // 8-pixel column of 10s with an R impulse on pixel 3.
    for (int i = 0; i < 8; i++) px[i] = {8'd10, 8'd10, 8'd10};
    px[3][0] = 8'd250;
    model_col(px, 8, ex);
    send_col(px, ex, 8, 1'b0, -1, 1'b0, 1'b1, k);
    idle(4);

    // Ramp-ish R column with hand-derived R outputs, followed back-to-back by
    // a random column containing an invalid beat and col_last on R/G beats.
    r_exp = '{8'd0, 8'd20, 8'd50, 8'd30, 8'd70, 8'd40, 8'd60, 8'd60};
    begin
      logic [7:0] r_in[8];
      r_in = '{8'd0, 8'd50, 8'd20, 8'd90, 8'd30, 8'd70, 8'd40, 8'd60};
      for (int i = 0; i < 8; i++) begin
        px[i][0] = r_in[i];
        px[i][1] = 8'(i * 30);
        px[i][2] = 8'(255 - i * 17);
      end
    end
    model_col(px, 8, ex);
    for (int i = 0; i < 8; i++) ex[i][0] = r_exp[i];
    send_col(px, ex, 8, 1'b0, -1, 1'b0, 1'b1, k);
    rand_col(7, px);
    model_col(px, 7, ex);
    send_col(px, ex, 7, 1'b0, 4, 1'b1, 1'b1, k);
    rand_col(5, px);
    model_col(px, 5, ex);
    send_col(px, ex, 5, 1'b1, -1, 1'b0, 1'b1, k);
    idle(2);

    // Single-pixel column.
    px[0] = '0;
    px[0][0] = 8'd5; px[0][1] = 8'd6; px[0][2] = 8'd7;
    model_col(px, 1, ex);
    send_col(px, ex, 1, 1'b0, -1, 1'b0, 1'b1, k);
    idle(4);

    // Table of 3-pixel columns exercising median ordering and ties.
    for (int t = 0; t < 8; t++) begin
      px[0] = {tbl[t].x0, tbl[t].x0, tbl[t].x0};
      px[1] = {tbl[t].x1, tbl[t].x1, tbl[t].x1};
      px[2] = {tbl[t].x2, tbl[t].x2, tbl[t].x2};
      ex[0] = {tbl[t].x0, tbl[t].x0, tbl[t].x0};
      ex[1] = {tbl[t].mid, tbl[t].mid, tbl[t].mid};
      ex[2] = {tbl[t].x2, tbl[t].x2, tbl[t].x2};
      send_col(px, ex, 3, t == 7, -1, 1'b0, 1'b1, k);
    end
    idle(4);

    // Reset sampled while FL_G is on the output register path: only FL_R appears.
    rand_col(4, px);
    model_col(px, 4, ex);
    send_col(px, ex, 4, 1'b1, -1, 1'b0, 1'b0, k);
    push_exp(ex[3][0], 2'd0, 1'b0, 1'b0, k + 1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    total++;
    if (out_bus.valid !== 1'b0 || out_bus.data !== 8'd0 || out_bus.color !== 2'd0 ||
        out_bus.col_last !== 1'b0 || out_bus.pic_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_flush_reset: got v=%b d=%0d c=%0d cl=%b pl=%b, want all 0",
               out_bus.valid, out_bus.data, out_bus.color, out_bus.col_last, out_bus.pic_last);
    end
    idle(6);

    // After reset the first-pixel flag is armed again.
    rand_col(2, px);
    model_col(px, 2, ex);
    send_col(px, ex, 2, 1'b1, -1, 1'b0, 1'b1, k);
    idle(8);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats outstanding, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/median_denoise.md
# median_denoise

Per-channel 3-tap median filter on the demosaic RGB output stream. It removes single-pixel impulse noise along each column strip before later ISP stages. It consumes the demosaic output beats one colour channel at a time and emits a stream in the same format. It applies one pixel of delay within each column and flushes the last pixel of each column.

## Interface
- DATA_W, 8, sample width per channel.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat strobe (demosaic RGB_valid).
- in_data  in  DATA_W  channel sample (RGB_data).
- in_color  in  2  channel: 0=R, 1=G, 2=B, 3=invalid (color).
- in_col_last  in  1  last pixel of the current column strip (col_last).
- in_pic_last  in  1  last pixel of the picture (pic_last).
- out_valid  out  1  output beat strobe.
- out_data  out  DATA_W  filtered sample.
- out_color  out  2  channel of out_data.
- out_col_last  out  1  on the final B beat of a column.
- out_pic_last  out  1  on the final B beat of a picture.

## Operation
- Input contract:
  - Each pixel arrives as three beats in order R, G, B.
  - At most one beat per cycle; no backpressure.
  - Columns are pixel sequences terminated by in_col_last.
- Beats with in_color=3 are ignored: no state change, no output.
- in_col_last and in_pic_last are honoured only on a B beat and ignored on R and G beats.
- Per channel c, two registers are held: a[c]=p[n-1] and b[c]=p[n]. A first-pixel flag is set by reset and after each honoured col_last.
- First pixel of a column, beat for channel c:
  - a[c] and b[c] both take the input sample.
  - No output.
- Later pixel, beat for channel c with sample x:
  - Emit median(a[c], b[c], x) with color c.
  - Then a[c] takes b[c] and b[c] takes x.
  - The median is an unsigned DATA_W compare; on ties it returns the repeated value.
- Edge replication:
  - Pixel 0 output = median(p0, p0, p1) = p0.
  - Last pixel output = p[H-1] (flush).
- Flush:
  - On the honoured col_last B beat, tail[0..2] takes {b[R], b[G], x_B}, and tail_pic takes in_pic_last.
  - FSM moves IDLE -> FL_R -> FL_G -> FL_B -> IDLE, one cycle per state.
  - Each state emits tail[c] with color c.
  - FL_B drives out_col_last=1 and out_pic_last=tail_pic.
- A new column may start during flush. Its pixel-0 beats produce no output and write only a/b, never tail, so there is no output or storage conflict.
- The first output of the new column is no earlier than its 4th beat, which falls after FL_B.
- Single-pixel column (col_last on pixel 0): no regular outputs; flush emits p0.
- Median-of-three uses three comparators. No arithmetic, so there is no width growth.

## Timing
- All outputs are registered.
- Reset values: out_valid=0, out_data=0, out_color=0, out_col_last=0, out_pic_last=0. Reset also clears FSM to IDLE, first-pixel flag to 1, and a, b, tail, tail_pic to 0.
- An input beat sampled at edge k produces its output (if any) registered at edge k, visible in cycle k..k+1. Latency is 1 cycle from beat to output of the previous pixel's same channel.
- A col_last B beat sampled at edge k gives:
  - regular output (pixel H-2, B) at edge k;
  - flush beats at edges k+1, k+2, k+3.
- out_col_last and out_pic_last pulse for one cycle, only with out_valid.
- A col_last received while flushing (column of at most 1 pixel arriving inside 3 cycles) is a contract violation and is not supported.
- Reset mid-flush aborts the flush; no further output until new input.

## Test plan
- Single column, 8 pixels, all channels 10 except R of pixel 3 = 250 -> 24 outputs. R of pixel 3 = 10; every other value 10; out_col_last only on the 24th beat.
- Column with R = 0, 50, 20, 90, 30, 70, 40, 60 -> R outputs 0, 20, 50, 30, 70, 40, 60, 60.
- Back-to-back columns: column B starts R0 at edge k+1 after column A's col_last at edge k -> flush beats at k+1..k+3 carry A's pixel 7. Column B's first output is at its 4th beat, with no dropped or duplicated beats.
- Picture end: in_col_last=in_pic_last=1 on the final B beat -> out_col_last=out_pic_last=1 on FL_B only. in_col_last asserted on a G beat -> ignored.
- Beat with in_color=3 mid-column -> no output and filter state unchanged. rst pulse during FL_G -> next cycle all outputs 0, FL_B never emitted.
- Single-pixel column (R=5, G=6, B=7, col_last) -> outputs exactly 5, 6, 7 at edges k+1..k+3, with col_last on 7.
